// File: rtl/synth_pkg.sv
// Shared constants and width helpers for the PDM/PCM datapath.
// Both the 1-bit DAC and the decimator size themselves from this package.
package synth_pkg;

    localparam int CIC_ORDER = 3;
    localparam int PCM_W     = 16;

    // Worst-case CIC gain is R^ORDER, so one extra bit holds the full-scale value.
    function automatic int cic_width(input int log2r);
        return CIC_ORDER * log2r + 1;
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// Single CIC integrator stage: W-bit accumulator that wraps modulo 2^W.
// The accumulator only advances on clock-enabled edges.
module cic_integrator #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] addend,
    output logic [W-1:0] acc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (ce) begin
            acc <= acc + addend;
        end
    end

endmodule

// File: rtl/pdm_decimator.sv
// Third-order CIC decimator turning a 1-bit PDM stream into 16-bit unsigned PCM.
// Integrators run at the ce rate; combs, scaling and settling run once per R ce-edges.
module pdm_decimator
    import synth_pkg::*;
#(
    parameter int LOG2R = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             din,
    output logic [PCM_W-1:0] dout,
    output logic             dout_valid
);

    localparam int W      = cic_width(LOG2R);
    localparam int GAIN_W = CIC_ORDER * LOG2R;
    localparam int SHIFT  = GAIN_W - PCM_W;
    localparam logic [1:0] SETTLE_LAST = 2'(CIC_ORDER);

    if (LOG2R < 6 || LOG2R > 8) begin : g_bad_log2r
        $error("pdm_decimator: LOG2R must be in the range 6..8");
    end

    logic [W-1:0]       stage_in;
    logic [W-1:0]       integ1;
    logic [W-1:0]       integ2;
    logic [W-1:0]       integ3;
    logic [LOG2R-1:0]   dec_cnt;
    logic               dec_evt;
    logic [W-1:0]       comb_d1;
    logic [W-1:0]       comb_d2;
    logic [W-1:0]       comb_d3;
    logic [W-1:0]       comb1;
    logic [W-1:0]       comb2;
    logic [W-1:0]       comb3;
    logic [W-1:0]       comb3_shr;
    logic [PCM_W-1:0]   pcm;
    logic [1:0]         settle_cnt;

    assign stage_in = {{(W-1){1'b0}}, din};

    cic_integrator #(.W(W)) u_integ1 (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .addend (stage_in),
        .acc    (integ1)
    );

    cic_integrator #(.W(W)) u_integ2 (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .addend (integ1),
        .acc    (integ2)
    );

    cic_integrator #(.W(W)) u_integ3 (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .addend (integ2),
        .acc    (integ3)
    );

    // The last ce-edge of each frame is the decimation edge.
    assign dec_evt = ce && (&dec_cnt);

    always_comb begin
        comb1     = integ3 - comb_d1;
        comb2     = comb1 - comb_d2;
        comb3     = comb2 - comb_d3;
        comb3_shr = comb3 >> SHIFT;
        pcm       = comb3_shr[PCM_W-1:0];
        // Only exact full scale (2^GAIN_W) sets the top bit; clamp it to 0xFFFF.
        if (comb3[W-1]) begin
            pcm = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt    <= '0;
            comb_d1    <= '0;
            comb_d2    <= '0;
            comb_d3    <= '0;
            settle_cnt <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (ce) begin
                dec_cnt <= dec_cnt + LOG2R'(1);
            end
            if (dec_evt) begin
                comb_d1 <= integ3;
                comb_d2 <= comb1;
                comb_d3 <= comb2;
                // The comb delays hold start-up garbage for the first ORDER frames.
                if (settle_cnt == SETTLE_LAST) begin
                    dout       <= pcm;
                    dout_valid <= 1'b1;
                end else begin
                    settle_cnt <= settle_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: doc/pdm_decimator.md
PDM_DECIMATOR -- requirements
Module: pdm_decimator

Interface
REQ-001 Parameter LOG2R, default 6, log2 of decimation ratio R = 2^LOG2R; legal range 6..8, out-of-range rejected at elaboration.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ce  input  1  clock enable; state advances only on edges with ce=1.
REQ-005 din  input  1  PDM bitstream, same format as the synth 1-bit DAC output; 1 = +1, 0 = 0.
REQ-006 dout  output  16  recovered unsigned PCM sample, held between updates.
REQ-007 dout_valid  output  1  one-clk strobe marking a new dout.

Function
REQ-008 Filter is a CIC: 3 integrators at input rate, decimate by R, 3 combs (differential delay 1) at output rate.
REQ-009 Internal width W = 3*LOG2R+1; integrators and combs wrap modulo 2^W; wrap is intended, never flagged.
REQ-010 Integrator chain is registered: din enters stage 1 at ce-edge k, stage 2 at k+1, stage 3 at k+2.
REQ-011 Decimation counter counts ce-edges 0..R-1 and wraps; when ce=1 and count=R-1, stage-3 value feeds the comb chain combinationally and comb delay registers update on that edge.
REQ-012 On that same edge dout and dout_valid are registered: dout_valid=1 for exactly the following clk cycle, else 0.
REQ-013 Scaling: comb result c (0..2^(3*LOG2R)); dout = c >> (3*LOG2R-16); if c = 2^(3*LOG2R), dout saturates to 0xFFFF.
REQ-014 Settling: first 3 decimation events after reset update internal state but hold dout_valid=0 and dout=0; 4th and later events strobe.
REQ-015 ce=0: integrators, counter, combs, dout frozen; dout_valid is 0 on any cycle not directly following a decimation edge.
REQ-016 ce toggling does not change result: output after N ce-edges equals output of continuous operation over N edges.
REQ-017 Steady state (after settling): all-ones din -> 0xFFFF; all-zeros -> 0x0000; alternating 1,0 -> 0x8000 exactly.
REQ-018 Output sample rate is exactly one dout_valid per R ce-edges; never two strobes closer than R clk cycles.

Reset
REQ-019 rst=1 at an edge clears all integrators, comb delays, decimation counter, settling counter; dout=0x0000, dout_valid=0 on the next cycle.
REQ-020 rst has priority over ce; reset mid-frame discards the partial frame and restarts settling per REQ-014.
REQ-021 No output depends on state from before the last reset.

Structure
REQ-022 Shared package synth_pkg holds CIC_ORDER=3, PCM_W=16 and the width function for W; no module-local copies.
REQ-023 One sub-module cic_integrator (W-bit wrapping accumulator with ce, rst) instantiated 3 times; combs, counter, scaling and settling in the top.
REQ-024 No multipliers; adders/subtractors and shifts only.

Verification
REQ-025 din=1 constant, ce=1, LOG2R=6: no dout_valid in first 3*64 cycles; subsequent strobes every 64 cycles with dout=0xFFFF.
REQ-026 din alternating 1,0, LOG2R=6: after settling every dout=0x8000; repeat for LOG2R=8, same value.
REQ-027 Loopback: synth dac fed constant 0x4000 drives din -> dout within 0x4000 +/- 0x0100 after settling.
REQ-028 ce pseudo-random 50% duty, din=1: strobe spacing counted in ce-edges equals 64; dout values identical to ce=1 run.
REQ-029 rst pulsed for one cycle mid-frame (count=30) during din=1: dout=0, dout_valid=0 next cycle; next strobe after full re-settling (4*64 ce-edges), value 0xFFFF.
REQ-030 Step din 0 -> 1 after settling: dout sequence monotone non-decreasing, reaches 0xFFFF within 3 output samples.
